riscv_mmio_timer_console: RTL

- Memory-mapped responder on the riscv_core data bus (daddr/dwdata/drdata/dsize/drd/dwr), sitting alongside riscv_memory.
- Provides a machine timer with a compare interrupt, plus a console TX FIFO.
- The FIFO drains bytes over a valid/ready byte stream to a UART or a testbench sink.
- The data-bus read mux selects this block when rd_hit_o is high.

---
 rtl/riscv_mmio_pkg.sv | 19 +
 rtl/riscv_sync_fifo.sv | 56 +++++
 rtl/riscv_mmio_timer_console.sv | 116 +++++++++++
 3 files changed

// File: rtl/riscv_mmio_pkg.sv
// Shared register-map offsets, CTRL bit positions and access-size encodings
// for the riscv MMIO peripherals.
package riscv_mmio_pkg;

  localparam logic [1:0] OFS_CTRL     = 2'd0;
  localparam logic [1:0] OFS_MTIME    = 2'd1;
  localparam logic [1:0] OFS_MTIMECMP = 2'd2;
  localparam logic [1:0] OFS_CONSOLE  = 2'd3;

  localparam int unsigned CTRL_TMR_EN  = 0;
  localparam int unsigned CTRL_IRQ_EN  = 1;
  localparam int unsigned CTRL_CLR_IRQ = 2;
  localparam int unsigned CTRL_CLR_OVF = 3;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/riscv_sync_fifo.sv
// Synchronous circular FIFO. A push into a full FIFO is accepted only when a pop
// happens in the same cycle; otherwise it is dropped and flagged on drop_o.
module riscv_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     drop_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_pop, do_push;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW + 1)'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign drop_o  = push_i & ~do_push;
  assign count_o = count_q;
  // Storage is not reset, so mask the head while empty to keep the output clean.
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (do_pop && !do_push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/riscv_mmio_timer_console.sv
// Data-bus MMIO responder: machine timer with compare interrupt and a console
// TX FIFO drained over a valid/ready byte stream.
module riscv_mmio_timer_console
  import riscv_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] daddr_i,
  input  logic [31:0] dwdata_i,
  input  logic [1:0]  dsize_i,
  input  logic        drd_i,
  input  logic        dwr_i,
  output logic [31:0] drdata_o,
  output logic        rd_hit_o,
  output logic        irq_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic        sel, wr_word, ctrl_wr, console_wr, rd_en;
  logic [1:0]  ofs;
  logic        tmr_en_q, irq_en_q, irq_pend_q, ovf_q;
  logic [31:0] mtime_q, mtimecmp_q, mtime_d, rd_val, drdata_q;
  logic        rd_hit_q, irq_set, irq_clr, ovf_set, ovf_clr;
  logic        fifo_full, fifo_empty, fifo_drop, pop;
  logic [CW-1:0] fifo_count;

  assign sel        = (daddr_i[31:4] == BASE_ADDR[31:4]);
  assign ofs        = daddr_i[3:2];
  assign wr_word    = dwr_i & sel & (dsize_i == SZ_WORD);
  assign ctrl_wr    = wr_word & (ofs == OFS_CTRL);
  assign console_wr = dwr_i & sel & (ofs == OFS_CONSOLE);
  assign rd_en      = drd_i & sel;

  assign pop     = tx_valid_o & tx_ready_i;
  assign irq_set = tmr_en_q & (mtime_q == mtimecmp_q);
  assign irq_clr = ctrl_wr & dwdata_i[CTRL_CLR_IRQ];
  assign ovf_set = fifo_drop;
  assign ovf_clr = ctrl_wr & dwdata_i[CTRL_CLR_OVF];

  always_comb begin
    mtime_d = mtime_q;
    if (wr_word && ofs == OFS_MTIME) begin
      mtime_d = dwdata_i;
    end else if (tmr_en_q) begin
      mtime_d = mtime_q + 32'd1;
    end
  end

  always_comb begin
    rd_val = '0;
    unique case (ofs)
      OFS_CTRL:     rd_val = {30'b0, irq_en_q, tmr_en_q};
      OFS_MTIME:    rd_val = mtime_q;
      OFS_MTIMECMP: rd_val = mtimecmp_q;
      OFS_CONSOLE:  rd_val = {16'b0, 8'(fifo_count), 4'b0, ovf_q, fifo_full, fifo_empty,
                              irq_pend_q};
      default:      rd_val = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      tmr_en_q   <= 1'b0;
      irq_en_q   <= 1'b0;
      irq_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
      mtime_q    <= '0;
      mtimecmp_q <= '0;
      drdata_q   <= '0;
      rd_hit_q   <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        tmr_en_q <= dwdata_i[CTRL_TMR_EN];
        irq_en_q <= dwdata_i[CTRL_IRQ_EN];
      end
      if (wr_word && ofs == OFS_MTIMECMP) begin
        mtimecmp_q <= dwdata_i;
      end
      mtime_q    <= mtime_d;
      // Sticky flags: a set in the same cycle as a clear takes priority.
      irq_pend_q <= irq_set | (irq_pend_q & ~irq_clr);
      ovf_q      <= ovf_set | (ovf_q & ~ovf_clr);
      drdata_q   <= rd_en ? rd_val : '0;
      rd_hit_q   <= rd_en;
    end
  end

  assign drdata_o   = drdata_q;
  assign rd_hit_o   = rd_hit_q;
  assign irq_o      = irq_pend_q & irq_en_q;
  assign tx_valid_o = ~fifo_empty;

  riscv_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (console_wr),
    .wdata_i (dwdata_i[7:0]),
    .pop_i   (pop),
    .rdata_o (tx_data_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .drop_o  (fifo_drop),
    .count_o (fifo_count)
  );

endmodule
